// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//
// Purpose
//   Shares one 2-stage pipelined 3-operand adder (sum = a + b + c, truncated
//   to WIDTH bits) between N_REQ requesters. A round-robin arbiter admits at
//   most one operand set per cycle. Each result leaves tagged with the index
//   of the requester that produced it.
//
// Ports
//   i_clk        clock, rising edge
//   i_arst_n     asynchronous reset, active low
//   i_req_valid  per-requester request valid            [N_REQ]
//   i_req_a/b/c  packed operands, requester k at [k*WIDTH +: WIDTH]
//   o_req_ready  per-requester grant, one-hot or zero   [N_REQ]
//   o_rsp_valid  response valid (stage 2 valid)
//   o_rsp_id     requester index of the response        [ID_W]
//   o_rsp_sum    (a + b + c) mod 2**WIDTH               [WIDTH]
//   i_rsp_ready  downstream accepts the response
//   o_busy       some pipeline stage holds a valid entry
//
// Handshake
//   A request from k transfers on a rising edge where i_req_valid[k] and
//   o_req_ready[k] are both high; the requester keeps valid and operands
//   stable until then. o_req_ready is combinational, never high for a
//   requester whose valid is low, and zero while the pipeline is stalled.
//   A response transfers on a rising edge where o_rsp_valid and i_rsp_ready
//   are both high; until then o_rsp_* hold their values.

module adder_share_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*WIDTH-1:0] i_req_a,
    input  logic [N_REQ*WIDTH-1:0] i_req_b,
    input  logic [N_REQ*WIDTH-1:0] i_req_c,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic                   o_rsp_valid,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic [WIDTH-1:0]       o_rsp_sum,
    input  logic                   i_rsp_ready,
    output logic                   o_busy
);

    // Round-robin pointer: requester where the next search starts.
    logic [ID_W-1:0]  ptr;

    // Stage 1: partial sum a+b, operand c, ID.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_ab;
    logic [WIDTH-1:0] s1_c;
    logic [ID_W-1:0]  s1_id;

    // Stage 2: final sum, drives the response outputs.
    logic             s2_valid;
    logic [WIDTH-1:0] s2_sum;
    logic [ID_W-1:0]  s2_id;

    // Arbitration results.
    logic             adv;
    logic             found;
    logic [ID_W-1:0]  gnt_idx;
    logic [N_REQ-1:0] grant;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] c_sel;

    // One global enable: every stage moves when the output slot is free
    // or being emptied this cycle.
    assign adv = !s2_valid || i_rsp_ready;

    // Search from ptr upward with wrap; first valid requester wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        a_sel   = '0;
        b_sel   = '0;
        c_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin : search
            int idx;
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && i_req_valid[idx]) begin
                found      = 1'b1;
                gnt_idx    = ID_W'(idx);
                grant[idx] = 1'b1;
                a_sel      = i_req_a[idx*WIDTH +: WIDTH];
                b_sel      = i_req_b[idx*WIDTH +: WIDTH];
                c_sel      = i_req_c[idx*WIDTH +: WIDTH];
            end
        end
    end

    // A grant is only offered when the pipeline advances; it is also held
    // off while reset is asserted so no requester sees a phantom transfer.
    assign o_req_ready = (adv && i_arst_n) ? grant : '0;

    // Pointer moves just past the winner; it holds when nothing is granted.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ptr <= '0;
        end else if (adv && found) begin
            ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Stage 1. Data registers only load with a real entry so bubbles do not
    // disturb the last operands.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            s1_valid <= 1'b0;
            s1_ab    <= '0;
            s1_c     <= '0;
            s1_id    <= '0;
        end else if (adv) begin
            s1_valid <= found;
            if (found) begin
                s1_ab <= a_sel + b_sel;
                s1_c  <= c_sel;
                s1_id <= gnt_idx;
            end
        end
    end

    // Stage 2. Response data only changes when a valid entry moves in, so
    // o_rsp_* stay put across bubbles and stalls.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_id    <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum <= s1_ab + s1_c;
                s2_id  <= s1_id;
            end
        end
    end

    assign o_rsp_valid = s2_valid;
    assign o_rsp_id    = s2_id;
    assign o_rsp_sum   = s2_sum;
    assign o_busy      = s1_valid || s2_valid;

endmodule
